// File: rtl/sdram_port_arbiter_if.sv
// Bundle of client-side and controller-side signals for sdram_port_arbiter.
// slave  : the arbiter's view (drives acks, rdata and the controller requests).
// master : the environment's view (clients plus SDRAM controller).
interface sdram_port_arbiter_if #(
  parameter int NPORTS = 3,
  parameter int AW     = 25,
  parameter int DW     = 16
);
  // client side
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    wr;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS-1:0]    ack;
  logic [DW-1:0]        rdata;
  logic [2:0]           grant_idx;
  logic                 busy;
  // controller side
  logic [AW-1:0]        sd_raddr;
  logic                 sd_rd;
  logic                 sd_rd_rdy;
  logic [DW-1:0]        sd_dout;
  logic [AW-1:0]        sd_waddr;
  logic [DW-1:0]        sd_din;
  logic                 sd_we;
  logic                 sd_we_ack;

  modport slave (
    input  req, wr, addr, wdata, sd_rd_rdy, sd_dout, sd_we_ack,
    output ack, rdata, grant_idx, busy, sd_raddr, sd_rd, sd_waddr, sd_din, sd_we
  );

  modport master (
    output req, wr, addr, wdata, sd_rd_rdy, sd_dout, sd_we_ack,
    input  ack, rdata, grant_idx, busy, sd_raddr, sd_rd, sd_waddr, sd_din, sd_we
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller between NPORTS requesters.
// Reads use the rising-edge sd_rd / sd_rd_rdy handshake, writes the sd_we /
// sd_we_ack toggle handshake. The winning port gets a one-cycle ack.
// Optional feature: define SDRAM_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority with port 0 highest.
module sdram_port_arbiter #(
  parameter int NPORTS        = 3,
  parameter int AW            = 25,
  parameter int DW            = 16,
  parameter int RD_LOW_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  sdram_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(RD_LOW_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LOW  = 3'd1,
    RD_HIGH = 3'd2,
    RD_GAP  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  state_t            state_reg;
  logic [NPORTS-1:0] ack_reg;
  logic [DW-1:0]     rdata_reg;
  logic [2:0]        grant_reg;
  logic              busy_reg;
  logic [AW-1:0]     sd_raddr_reg;
  logic              sd_rd_reg;
  logic [AW-1:0]     sd_waddr_reg;
  logic [DW-1:0]     sd_din_reg;
  logic              sd_we_reg;
  logic [CW-1:0]     gap_cnt_reg;

  logic              in_gap;
  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] grant_onehot;
  logic [2:0]        search_start;
  logic              win_valid;
  logic [2:0]        win_idx;
  logic [NPORTS-1:0] win_onehot;
  logic              win_wr;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;

  assign in_gap = (state_reg == RD_GAP);

  // A port is eligible unless it is being acked this very cycle (its req is
  // still up while it sees the ack); during the read gap only writes qualify.
  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      assign elig[gi]         = bus.req[gi] & ~ack_reg[gi] & (~in_gap | bus.wr[gi]);
      assign grant_onehot[gi] = (grant_reg == 3'(gi));
    end
  endgenerate

`ifdef SDRAM_ARB_RR_EN
  logic [2:0] ptr_reg;

  // Search begins one past the last granted port, wrapping at NPORTS.
  assign search_start = (ptr_reg == 3'(NPORTS - 1)) ? 3'd0 : ptr_reg + 3'd1;

  // Pointer remembers the most recent grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= 3'(NPORTS - 1);
    end else if ((state_reg == IDLE || state_reg == RD_GAP) && win_valid) begin
      ptr_reg <= win_idx;
    end
  end
`else
  assign search_start = 3'd0;
`endif

  // Rotating priority pick: first eligible port at or above search_start,
  // else the first eligible port from 0; then mux the winner's request.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = 3'd0;
    win_onehot = '0;
    win_wr     = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (!win_valid && elig[p] && (3'(p) >= search_start)) begin
        win_valid     = 1'b1;
        win_idx       = 3'(p);
        win_onehot[p] = 1'b1;
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (!win_valid && elig[p]) begin
        win_valid     = 1'b1;
        win_idx       = 3'(p);
        win_onehot[p] = 1'b1;
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (win_onehot[p]) begin
        win_wr    = bus.wr[p];
        win_addr  = bus.addr[p*AW +: AW];
        win_wdata = bus.wdata[p*DW +: DW];
      end
    end
  end

  // Transfer sequencer with registered controller and client outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ack_reg      <= '0;
      rdata_reg    <= '0;
      grant_reg    <= 3'd0;
      busy_reg     <= 1'b0;
      sd_raddr_reg <= '0;
      sd_rd_reg    <= 1'b0;
      sd_waddr_reg <= '0;
      sd_din_reg   <= '0;
      sd_we_reg    <= bus.sd_we_ack;  // matching ack means no write pending
      gap_cnt_reg  <= '0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE, RD_GAP: begin
          if (state_reg == RD_GAP) begin
            if (gap_cnt_reg == CW'(RD_LOW_CYCLES - 1)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
          end
          // A grant overrides the gap bookkeeping above (only writes reach here in RD_GAP).
          if (win_valid) begin
            grant_reg <= win_idx;
            busy_reg  <= 1'b1;
            if (win_wr) begin
              sd_waddr_reg <= win_addr;
              sd_din_reg   <= win_wdata;
              sd_we_reg    <= ~sd_we_reg;
              state_reg    <= WR_WAIT;
            end else begin
              sd_raddr_reg <= win_addr;
              sd_rd_reg    <= 1'b1;
              state_reg    <= RD_LOW;
            end
          end
        end
        RD_LOW: begin
          if (!bus.sd_rd_rdy) state_reg <= RD_HIGH;
        end
        RD_HIGH: begin
          if (bus.sd_rd_rdy) begin
            rdata_reg   <= bus.sd_dout;
            ack_reg     <= grant_onehot;
            sd_rd_reg   <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= RD_GAP;
          end
        end
        WR_WAIT: begin
          if (bus.sd_we_ack == sd_we_reg) begin
            ack_reg   <= grant_onehot;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.grant_idx = grant_reg;
  assign bus.busy      = busy_reg;
  assign bus.sd_raddr  = sd_raddr_reg;
  assign bus.sd_rd     = sd_rd_reg;
  assign bus.sd_waddr  = sd_waddr_reg;
  assign bus.sd_din    = sd_din_reg;
  assign bus.sd_we     = sd_we_reg;
endmodule
